// File: rtl/axi_pkg.sv
// rtl/axi_pkg.sv - shared AXI4-Lite response codes, LSU size encodings and master FSM state type
package axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;
    localparam logic [1:0] DECERR = 2'b11;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_ADDR = 3'd1,
        ST_RD_DATA = 3'd2,
        ST_WR_REQ  = 3'd3,
        ST_WR_RESP = 3'd4,
        ST_RESP    = 3'd5
    } lsu_axi_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// rtl/axi_lite_if.sv - AXI4-Lite bus bundle with master and slave views
interface axi_lite_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores, lane extraction and extension for loads
module lsu_lane_align
    import axi_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    input  logic [31:0] st_data,
    input  logic [31:0] ld_word,
    output logic [31:0] st_lane,
    output logic [3:0]  st_strb,
    output logic [31:0] ld_data,
    output logic        misaligned
);
    logic [31:0] lane;

    // steer store data up to its lane, pull load data down and extend it by size
    always_comb begin
        st_lane = st_data << {addr_lo, 3'b000};
        lane    = ld_word >> {addr_lo, 3'b000};
        case (size)
            SZ_B: begin
                st_strb    = 4'b0001 << addr_lo;
                ld_data    = {{24{lane[7] & ~is_unsigned}}, lane[7:0]};
                misaligned = 1'b0;
            end
            SZ_H: begin
                st_strb    = 4'b0011 << addr_lo;
                ld_data    = {{16{lane[15] & ~is_unsigned}}, lane[15:0]};
                misaligned = addr_lo[0];
            end
            SZ_W: begin
                st_strb    = 4'b1111;
                ld_data    = ld_word;
                misaligned = |addr_lo;
            end
            default: begin
                st_strb    = 4'b0000;
                ld_data    = 32'd0;
                misaligned = 1'b1;
            end
        endcase
    end
endmodule

// File: rtl/lsu_axi_master.sv
// rtl/lsu_axi_master.sv - single-outstanding LSU request to AXI4-Lite read/write master
module lsu_axi_master
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_wen,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    axi_lite_if.master        m
);
    lsu_axi_state_t    state;
    logic [ADDR_W-1:0] ax_addr_q;
    logic [1:0]        addr_lo_q;
    logic [1:0]        size_q;
    logic              uns_q;
    logic              wen_q;
    logic [31:0]       wdata_q;
    logic [3:0]        wstrb_q;
    logic [31:0]       rdata_q;
    logic              err_q;
    logic              aw_done;
    logic              w_done;

    logic [1:0]        al_addr_lo;
    logic [1:0]        al_size;
    logic              al_unsigned;
    logic [31:0]       st_lane;
    logic [3:0]        st_strb;
    logic [31:0]       ld_data;
    logic              misaligned;
    logic              aw_hs;
    logic              w_hs;

    // in IDLE the aligner sees the incoming request; afterwards it sees the captured one
    always_comb begin
        al_addr_lo  = (state == ST_IDLE) ? req_addr[1:0] : addr_lo_q;
        al_size     = (state == ST_IDLE) ? req_size      : size_q;
        al_unsigned = (state == ST_IDLE) ? req_unsigned  : uns_q;
    end

    lsu_lane_align u_align (
        .addr_lo     (al_addr_lo),
        .size        (al_size),
        .is_unsigned (al_unsigned),
        .st_data     (req_wdata),
        .ld_word     (rdata_q),
        .st_lane     (st_lane),
        .st_strb     (st_strb),
        .ld_data     (ld_data),
        .misaligned  (misaligned)
    );

    assign aw_hs = m.awvalid && m.awready;
    assign w_hs  = m.wvalid && m.wready;

    // handshake outputs decode straight from state so reset clears them on the same edge
    always_comb begin
        req_ready  = (state == ST_IDLE);
        resp_valid = (state == ST_RESP);
        resp_err   = (state == ST_RESP) && err_q;
        resp_rdata = (state == ST_RESP && !err_q && !wen_q) ? ld_data : 32'd0;
        m.arvalid  = (state == ST_RD_ADDR);
        m.araddr   = ax_addr_q;
        m.rready   = (state == ST_RD_DATA);
        m.awvalid  = (state == ST_WR_REQ) && !aw_done;
        m.awaddr   = ax_addr_q;
        m.wvalid   = (state == ST_WR_REQ) && !w_done;
        m.wdata    = wdata_q;
        m.wstrb    = wstrb_q;
        m.bready   = (state == ST_WR_RESP);
    end

    // transaction sequencing: capture, address/data phases, response pulse
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            ax_addr_q <= '0;
            addr_lo_q <= 2'd0;
            size_q    <= 2'd0;
            uns_q     <= 1'b0;
            wen_q     <= 1'b0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            rdata_q   <= 32'd0;
            err_q     <= 1'b0;
            aw_done   <= 1'b0;
            w_done    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        ax_addr_q <= {req_addr[ADDR_W-1:2], 2'b00};
                        addr_lo_q <= req_addr[1:0];
                        size_q    <= req_size;
                        uns_q     <= req_unsigned;
                        wen_q     <= req_wen;
                        wdata_q   <= st_lane;
                        wstrb_q   <= st_strb;
                        rdata_q   <= 32'd0;
                        err_q     <= misaligned;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (misaligned)   state <= ST_RESP;
                        else if (req_wen) state <= ST_WR_REQ;
                        else              state <= ST_RD_ADDR;
                    end
                end
                ST_RD_ADDR: begin
                    if (m.arready) state <= ST_RD_DATA;
                end
                ST_RD_DATA: begin
                    if (m.rvalid) begin
                        rdata_q <= m.rdata;
                        err_q   <= (m.rresp != OKAY);
                        state   <= ST_RESP;
                    end
                end
                ST_WR_REQ: begin
                    if ((aw_done || aw_hs) && (w_done || w_hs)) begin
                        aw_done <= 1'b0;
                        w_done  <= 1'b0;
                        state   <= ST_WR_RESP;
                    end else begin
                        if (aw_hs) aw_done <= 1'b1;
                        if (w_hs)  w_done  <= 1'b1;
                    end
                end
                ST_WR_RESP: begin
                    if (m.bvalid) begin
                        err_q <= (m.bresp != OKAY);
                        state <= ST_RESP;
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_axi_master.sv
// tb/tb_lsu_axi_master.sv - directed vector bench for lsu_axi_master
module tb_lsu_axi_master;
    import axi_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [31:0] req_addr;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int total = 0;
    int bad   = 0;

    axi_lite_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    lsu_axi_master #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wen      (req_wen),
        .req_addr     (req_addr),
        .req_size     (req_size),
        .req_unsigned (req_unsigned),
        .req_wdata    (req_wdata),
        .resp_valid   (resp_valid),
        .resp_rdata   (resp_rdata),
        .resp_err     (resp_err),
        .m            (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] wdata;
        logic [31:0] bus_rdata;
        logic [1:0]  bus_resp;
        int          exp_lat;
        logic        exp_bus;
        logic [31:0] exp_ax;
        logic [31:0] exp_wd;
        logic [3:0]  exp_ws;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic slave_idle();
        bus.awready = 1'b0;
        bus.wready  = 1'b0;
        bus.bvalid  = 1'b0;
        bus.bresp   = 2'b00;
        bus.arready = 1'b0;
        bus.rvalid  = 1'b0;
        bus.rdata   = 32'd0;
        bus.rresp   = 2'b00;
    endtask

    task automatic drive_req(input logic wen, input logic [31:0] addr, input logic [1:0] size,
                             input logic uns, input logic [31:0] wdata);
        req_valid    = 1'b1;
        req_wen      = wen;
        req_addr     = addr;
        req_size     = size;
        req_unsigned = uns;
        req_wdata    = wdata;
    endtask

    // immediate-ready slave; records what the master presents on each channel
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        logic        got, seen, overlap;
        logic [31:0] ax, wd, rd;
        logic [3:0]  ws;
        logic        er;
        int          lat;
        got = 0; seen = 0; overlap = 0; ax = 0; wd = 0; ws = 0; rd = 0; er = 0; lat = 0;
        @(negedge clk);
        chk($sformatf("v%0d req_ready", idx), {31'd0, req_ready}, 32'd1);
        drive_req(v.wen, v.addr, v.size, v.uns, v.wdata);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 1;
        while (!got && cyc < 20) begin
            slave_idle();
            if ((bus.arvalid || bus.rready) && (bus.awvalid || bus.wvalid || bus.bready))
                overlap = 1;
            if (resp_valid) begin
                got = 1; lat = cyc; rd = resp_rdata; er = resp_err;
            end else begin
                if (bus.arvalid) begin seen = 1; ax = bus.araddr; bus.arready = 1'b1; end
                if (bus.rready) begin
                    seen = 1; bus.rvalid = 1'b1; bus.rdata = v.bus_rdata; bus.rresp = v.bus_resp;
                end
                if (bus.awvalid) begin seen = 1; ax = bus.awaddr; bus.awready = 1'b1; end
                if (bus.wvalid) begin
                    seen = 1; wd = bus.wdata; ws = bus.wstrb; bus.wready = 1'b1;
                end
                if (bus.bready) begin seen = 1; bus.bvalid = 1'b1; bus.bresp = v.bus_resp; end
                @(negedge clk);
                cyc++;
            end
        end
        chk($sformatf("v%0d resp seen", idx), {31'd0, got}, 32'd1);
        chk($sformatf("v%0d latency", idx), lat, v.exp_lat);
        chk($sformatf("v%0d rdata", idx), rd, v.exp_rdata);
        chk($sformatf("v%0d err", idx), {31'd0, er}, {31'd0, v.exp_err});
        chk($sformatf("v%0d bus activity", idx), {31'd0, seen}, {31'd0, v.exp_bus});
        chk($sformatf("v%0d rd/wr overlap", idx), {31'd0, overlap}, 32'd0);
        if (v.exp_bus) chk($sformatf("v%0d axaddr", idx), ax, v.exp_ax);
        if (v.exp_bus && v.wen) begin
            chk($sformatf("v%0d wdata", idx), wd, v.exp_wd);
            chk($sformatf("v%0d wstrb", idx), {28'd0, ws}, {28'd0, v.exp_ws});
        end
        @(negedge clk);
        chk($sformatf("v%0d pulse one cycle", idx), {31'd0, resp_valid}, 32'd0);
        chk($sformatf("v%0d back to idle", idx), {31'd0, req_ready}, 32'd1);
    endtask

    initial begin
        //          wen  addr          size  uns  wdata         bus_rdata     resp    lat bus  exp_ax        exp_wd        ws       exp_rdata     err
        vecs[0]  = '{1'b0, 32'ha0000048, SZ_W, 1'b0, 32'h0,         32'h12345678, OKAY,   3, 1'b1, 32'ha0000048, 32'h0,        4'h0,    32'h12345678, 1'b0};
        vecs[1]  = '{1'b0, 32'h80000003, SZ_B, 1'b0, 32'h0,         32'h80FF00AA, OKAY,   3, 1'b1, 32'h80000000, 32'h0,        4'h0,    32'hFFFFFF80, 1'b0};
        vecs[2]  = '{1'b0, 32'h80000003, SZ_B, 1'b1, 32'h0,         32'h80FF00AA, OKAY,   3, 1'b1, 32'h80000000, 32'h0,        4'h0,    32'h00000080, 1'b0};
        vecs[3]  = '{1'b0, 32'h80000002, SZ_H, 1'b0, 32'h0,         32'h80FF00AA, OKAY,   3, 1'b1, 32'h80000000, 32'h0,        4'h0,    32'hFFFF80FF, 1'b0};
        vecs[4]  = '{1'b0, 32'h00000000, SZ_H, 1'b1, 32'h0,         32'h1234ABCD, OKAY,   3, 1'b1, 32'h00000000, 32'h0,        4'h0,    32'h0000ABCD, 1'b0};
        vecs[5]  = '{1'b0, 32'h00000001, SZ_B, 1'b0, 32'h0,         32'h00007F00, OKAY,   3, 1'b1, 32'h00000000, 32'h0,        4'h0,    32'h0000007F, 1'b0};
        vecs[6]  = '{1'b0, 32'h00000010, SZ_W, 1'b0, 32'h0,         32'hDEADBEEF, SLVERR, 3, 1'b1, 32'h00000010, 32'h0,        4'h0,    32'h00000000, 1'b1};
        vecs[7]  = '{1'b1, 32'h80000002, SZ_H, 1'b0, 32'h0000BEEF,  32'h0,        OKAY,   3, 1'b1, 32'h80000000, 32'hBEEF0000, 4'b1100, 32'h00000000, 1'b0};
        vecs[8]  = '{1'b1, 32'h20000001, SZ_B, 1'b0, 32'h123456A5,  32'h0,        OKAY,   3, 1'b1, 32'h20000000, 32'h3456A500, 4'b0010, 32'h00000000, 1'b0};
        vecs[9]  = '{1'b1, 32'h00000040, SZ_W, 1'b0, 32'hCAFEF00D,  32'h0,        DECERR, 3, 1'b1, 32'h00000040, 32'hCAFEF00D, 4'b1111, 32'h00000000, 1'b1};
        vecs[10] = '{1'b0, 32'h80000001, SZ_W, 1'b0, 32'h0,         32'h0,        OKAY,   1, 1'b0, 32'h0,        32'h0,        4'h0,    32'h00000000, 1'b1};
        vecs[11] = '{1'b1, 32'h00000003, SZ_H, 1'b0, 32'h00001111,  32'h0,        OKAY,   1, 1'b0, 32'h0,        32'h0,        4'h0,    32'h00000000, 1'b1};
        vecs[12] = '{1'b0, 32'h00000000, 2'd3, 1'b0, 32'h0,         32'h0,        OKAY,   1, 1'b0, 32'h0,        32'h0,        4'h0,    32'h00000000, 1'b1};

        reset = 1'b1;
        req_valid = 1'b0; req_wen = 1'b0; req_addr = 32'd0; req_size = 2'd0;
        req_unsigned = 1'b0; req_wdata = 32'd0;
        slave_idle();
        repeat (3) @(negedge clk);
        chk("reset req_ready", {31'd0, req_ready}, 32'd1);
        chk("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'd0);
        chk("reset resp_err", {31'd0, resp_err}, 32'd0);
        chk("reset valids", {28'd0, bus.arvalid, bus.awvalid, bus.wvalid, 1'b0}, 32'd0);
        chk("reset readies", {30'd0, bus.rready, bus.bready}, 32'd0);
        chk("reset araddr", bus.araddr, 32'd0);
        chk("reset awaddr", bus.awaddr, 32'd0);
        chk("reset wdata", bus.wdata, 32'd0);
        chk("reset wstrb", {28'd0, bus.wstrb}, 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 13; i++) run_vec(vecs[i], i);

        // store where aw is accepted at once and w two cycles later, slave answers SLVERR
        @(negedge clk);
        drive_req(1'b1, 32'ha0000048, SZ_W, 1'b0, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b0;
        slave_idle();
        chk("split aw+w raised", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        chk("split awaddr", bus.awaddr, 32'ha0000048);
        bus.awready = 1'b1;
        @(negedge clk);
        slave_idle();
        chk("split aw dropped c2", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
        chk("split no bready c2", {31'd0, bus.bready}, 32'd0);
        @(negedge clk);
        chk("split aw dropped c3", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
        chk("split wdata", bus.wdata, 32'h11223344);
        chk("split wstrb", {28'd0, bus.wstrb}, 32'hF);
        bus.wready = 1'b1;
        @(negedge clk);
        slave_idle();
        chk("split w dropped", {31'd0, bus.wvalid}, 32'd0);
        chk("split bready", {31'd0, bus.bready}, 32'd1);
        bus.bvalid = 1'b1;
        bus.bresp  = SLVERR;
        @(negedge clk);
        slave_idle();
        chk("split resp_valid", {31'd0, resp_valid}, 32'd1);
        chk("split resp_err", {31'd0, resp_err}, 32'd1);
        chk("split resp_rdata", resp_rdata, 32'd0);
        @(negedge clk);
        chk("split pulse one cycle", {31'd0, resp_valid}, 32'd0);

        // reset while waiting in RD_DATA abandons the load
        drive_req(1'b0, 32'h00000100, SZ_W, 1'b0, 32'd0);
        @(negedge clk);
        req_valid = 1'b0;
        slave_idle();
        chk("rst arvalid", {31'd0, bus.arvalid}, 32'd1);
        bus.arready = 1'b1;
        @(negedge clk);
        slave_idle();
        chk("rst in rd_data", {31'd0, bus.rready}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rst arvalid low", {31'd0, bus.arvalid}, 32'd0);
        chk("rst rready low", {31'd0, bus.rready}, 32'd0);
        chk("rst req_ready", {31'd0, req_ready}, 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("rst no resp c%0d", k), {31'd0, resp_valid}, 32'd0);
            @(negedge clk);
        end

        run_vec(vecs[0], 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lsu_axi_master.md
Name: lsu_axi_master

Overview:
AXI4-Lite master that turns the core LSU's single-outstanding load/store request into AXI4-Lite read or write transactions on the shared axi_lite_if. It is the initiator counterpart of the bus's slave devices (CLINT, UART, SRAM) and sits between the LSU and the crossbar.
- Handles size/alignment: byte-lane steering, wstrb generation and load sign/zero extension.
- Returns a single-cycle response to the LSU.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; only 32 is supported

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  LSU request valid
- req_ready  output  1  master can accept a request
- req_wen  input  1  1 = store, 0 = load
- req_addr  input  32  byte address
- req_size  input  2  0 = byte, 1 = half, 2 = word; 3 is illegal
- req_unsigned  input  1  load zero-extends when 1
- req_wdata  input  32  store data, LSB-aligned
- resp_valid  output  1  one-cycle response pulse
- resp_rdata  output  32  extended load data; 0 for stores
- resp_err  output  1  bus error or misaligned/illegal request
- m  interface  axi_lite_if.master  AXI4-Lite master port (aw/w/b/ar/r channels)

Behaviour:
- Reset values: req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0. All m.*valid and m.*ready outputs are 0. awaddr, araddr, wdata and wstrb are 0.
- Reset mid-transaction: every valid/ready output drops on the next edge and the FSM returns to IDLE. The abandoned transaction is not completed.
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RESP. The state type goes in the package.
- IDLE:
  - req_ready=1.
  - When req_valid, capture addr, size, unsigned flag, wen and steered data.
  - Misaligned (half with addr[0]=1, word with addr[1:0]!=0) or size==3 -> RESP with err=1. No bus activity.
  - Otherwise a load goes to RD_ADDR and a store goes to WR_REQ.
- RD_ADDR:
  - arvalid=1, araddr = {addr[31:2],2'b00}.
  - On arvalid&&arready -> RD_DATA.
  - araddr is held stable while arvalid is high.
- RD_DATA:
  - rready=1.
  - On rvalid: latch rdata and err = (rresp!=0) -> RESP.
- WR_REQ:
  - awvalid and wvalid are raised together in the first cycle.
  - Each valid drops independently after its own handshake, tracked by aw_done and w_done flags.
  - Both handshakes in the same cycle is legal.
  - When both are done -> WR_RESP.
  - awaddr = word-aligned address. wdata = req_wdata << (8*addr[1:0]).
  - wstrb: byte = 4'b0001<<addr[1:0]; half = 4'b0011<<addr[1:0]; word = 4'b1111.
- WR_RESP:
  - bready=1.
  - On bvalid: err = (bresp!=0) -> RESP.
- RESP:
  - resp_valid=1 for exactly one cycle, then IDLE.
  - The LSU must accept it; there is no backpressure.
  - resp_rdata for loads: lane = rdata >> (8*addr[1:0]). Byte/half are sign-extended from bit 7/15 unless req_unsigned. Word is passed unchanged.
  - resp_rdata is 0 for stores and for error responses.
- Latency:
  - Load with arready and rvalid both immediate: request accepted at cycle 0, arvalid at cycle 1, rvalid at cycle 2, resp_valid at cycle 3.
  - Misaligned request: resp_valid at cycle 1.
- req_ready=0 in every state except IDLE. Exactly one transaction is outstanding at a time.
- Write and read channels are never active simultaneously.

Decomposition:
- Shared package axi_pkg holds:
  - AXI resp constants: OKAY=2'b00, SLVERR=2'b10, DECERR=2'b11.
  - Size encodings: SZ_B, SZ_H, SZ_W.
  - The lsu_axi_state_t enum.
- One natural sub-module, lsu_lane_align: combinational wstrb/wdata steering plus load extraction and extension. It is unit-testable in isolation.

Test Plan:
- Word load at 0xa0000048, slave drives arready=1 and rvalid one cycle later with rdata=0x12345678, rresp=0 -> araddr=0xa0000048; resp_valid at cycle 3, resp_rdata=0x12345678, err=0.
- Byte load at addr 0x80000003, rdata=0x80FF00AA:
  - req_unsigned=0 -> resp_rdata=0xFFFFFF80.
  - req_unsigned=1 -> resp_rdata=0x00000080.
- Half store 0xBEEF to 0x80000002 -> awaddr=0x80000000, wdata=0xBEEF0000, wstrb=4'b1100. bresp=0 -> err=0.
- Store to 0xa0000048 where the slave accepts aw first, w two cycles later, and returns bresp=2'b10 -> awvalid drops after its handshake while wvalid stays high until its own; resp_err=1.
- Word load at 0x80000001 -> no arvalid ever asserted; resp_valid at cycle 1 with err=1.
- Reset asserted while in RD_DATA -> next cycle arvalid=rready=0, req_ready=1; no resp_valid pulse.
